// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode, funct and field-kind constants for encoder and decoder
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] SLT = 6'b101010;
  typedef enum logic [2:0] {
    K_RTYPE = 3'd0,
    K_LW    = 3'd1,
    K_SW    = 3'd2,
    K_BEQ   = 3'd3,
    K_ADDI  = 3'd4,
    K_J     = 3'd5
  } kind_e;
  function automatic logic kind_legal(input logic [2:0] k);
    return k <= K_J;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry first-word-fall-through FIFO; clk/rst/flush, push+din in, pop out via head, full/empty flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes MIPS field bundles (in_valid/in_ready handshake) into a FIFO and drains them as mem_we/mem_addr/mem_wdata writes gated by mem_ready; restart flushes, err_illegal and words_written report status
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              restart,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_illegal,
  output logic [ADDR_W:0]   words_written
);
  logic full, empty, pop, push, accept, legal;
  logic [31:0] enc, head;
  logic [5:0] op;
  logic [ADDR_W-1:0] addr;
  always_comb begin
    op = in_kind == K_LW ? OP_LW : in_kind == K_SW ? OP_SW : in_kind == K_BEQ ? OP_BEQ : OP_ADDI;
    enc = in_kind == K_RTYPE ? {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, in_funct}
        : in_kind == K_J ? {OP_J, in_target}
        : {op, in_rs, in_rt, in_imm};
    legal = kind_legal(in_kind);
    pop = !empty && mem_ready && !restart;
    in_ready = !full || pop;
    accept = in_valid && in_ready && !restart;
    push = accept && legal;
  end
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .flush(restart),
    .push(push),
    .pop(pop),
    .din(enc),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      mem_we <= 1'b0;
      mem_addr <= BASE_ADDR;
      addr <= BASE_ADDR;
      words_written <= '0;
      err_illegal <= 1'b0;
      if (reset) mem_wdata <= '0;
    end else begin
      mem_we <= pop;
      if (pop) begin
        mem_addr <= addr;
        mem_wdata <= head;
        addr <= addr + 1'b1;
        words_written <= &words_written ? words_written : words_written + 1'b1;
      end
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench driving a 6-bit-address and a 2-bit-address loader with identical stimulus
module tb_instr_encoder_loader;
  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;
  logic clk = 0, reset = 1, in_valid = 0, restart = 0, mem_ready = 1;
  logic [2:0] in_kind = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [5:0] in_funct = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_target = 0;
  logic in_ready_a, mem_we_a, err_a, in_ready_b, mem_we_b, err_b;
  logic [5:0] mem_addr_a;
  logic [1:0] mem_addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [6:0] ww_a;
  logic [2:0] ww_b;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_vec = 0, n_miss = 0, exp_addr = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(6)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .restart(restart), .mem_ready(mem_ready), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(wdata_a), .err_illegal(err_a), .words_written(ww_a)
  );
  instr_encoder_loader #(.DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .restart(restart), .mem_ready(mem_ready), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(wdata_b), .err_illegal(err_b), .words_written(ww_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (mem_we_a) begin
      if (qa.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected write a: addr 0x%0h data 0x%0h, none expected", mem_addr_a, wdata_a);
      end else begin
        ea = qa.pop_front();
        chk("addr a", 32'(mem_addr_a), 32'(ea.addr % 64));
        chk("data a", wdata_a, ea.data);
      end
    end
    if (mem_we_b) begin
      if (qb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected write b: addr 0x%0h data 0x%0h, none expected", mem_addr_b, wdata_b);
      end else begin
        eb = qb.pop_front();
        chk("addr b (wrap)", 32'(mem_addr_b), 32'(eb.addr % 4));
        chk("data b", wdata_b, eb.data);
      end
    end
  end

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [5:0] f, input logic [15:0] imm, input logic [25:0] t, input logic [31:0] exp);
    int w = 0;
    in_valid = 1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f; in_imm = imm; in_target = t;
    #1;
    while (!in_ready_a && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready_a) begin
      n_vec++; n_miss++;
      $display("FAIL accept timeout: in_ready stayed 0 for %0d cycles, required 1", w);
    end
    @(posedge clk);
    if (k <= 3'd5) begin
      qa.push_back('{exp_addr, exp});
      qb.push_back('{exp_addr, exp});
      exp_addr++;
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 60) begin
      @(negedge clk); #1; w++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain timeout: %0d/%0d writes outstanding, required 0", qa.size(), qb.size());
    end
    @(negedge clk);
  endtask

  task automatic do_restart(input logic with_bundle);
    restart = 1; in_valid = with_bundle; in_kind = 3'd5; in_target = 26'h3FFFFFF;
    @(posedge clk); #1;
    qa.delete(); qb.delete(); exp_addr = 0;
    @(negedge clk);
    restart = 0; in_valid = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready_a), 1);
    chk("reset mem_we", 32'(mem_we_a), 0);
    chk("reset mem_addr", 32'(mem_addr_a), 0);
    chk("reset mem_wdata", wdata_a, 0);
    chk("reset err_illegal", 32'(err_a), 0);
    chk("reset words_written", 32'(ww_a), 0);
    reset = 0;
    @(negedge clk);
    // single ADDI with latency check
    send(3'd4, 0, 8, 0, 0, 16'h0005, 0, 32'h20080005);
    chk("latency N+1 mem_we", 32'(mem_we_a), 0);
    @(negedge clk);
    chk("latency N+2 mem_we", 32'(mem_we_a), 1);
    drain();
    chk("single words_written", 32'(ww_a), 1);
    do_restart(0);
    // mixed stream; dut_b wraps 0,1,2,3,0
    send(3'd0, 8, 9, 10, 6'b100000, 0, 0, 32'h01095020);
    send(3'd1, 0, 8, 0, 0, 16'h0004, 0, 32'h8C080004);
    send(3'd2, 0, 8, 0, 0, 16'h0008, 0, 32'hAC080008);
    send(3'd3, 8, 9, 0, 0, 16'hFFFF, 0, 32'h1109FFFF);
    send(3'd5, 0, 0, 0, 0, 0, 26'h0000010, 32'h08000010);
    drain();
    chk("stream words_written", 32'(ww_a), 5);
    chk("stream words_written b", 32'(ww_b), 5);
    chk("stream last addr", 32'(mem_addr_a), 4);
    chk("wrap last addr b", 32'(mem_addr_b), 0);
    // backpressure: DEPTH accepts then stall
    mem_ready = 0;
    for (int i = 1; i <= 4; i++)
      send(3'd4, 0, 5'(i), 0, 0, 16'(8'h11 * i), 0, 32'h20000000 | (i << 16) | (8'h11 * i));
    in_valid = 1; in_kind = 3'd4; in_rs = 0; in_rt = 5; in_imm = 16'h0055;
    #1;
    chk("full in_ready", 32'(in_ready_a), 0);
    @(negedge clk); #1;
    chk("stalled in_ready", 32'(in_ready_a), 0);
    chk("stalled mem_we", 32'(mem_we_a), 0);
    mem_ready = 1;
    send(3'd4, 0, 5, 0, 0, 16'h0055, 0, 32'h20050055);
    drain();
    // illegal kind between two legal bundles
    do_restart(0);
    send(3'd1, 1, 2, 0, 0, 16'h0010, 0, 32'h8C220010);
    send(3'd7, 1, 1, 1, 0, 16'hDEAD, 0, 32'h0);
    send(3'd2, 3, 4, 0, 0, 16'h0020, 0, 32'hAC640020);
    drain();
    chk("illegal err_illegal", 32'(err_a), 1);
    chk("illegal words_written", 32'(ww_a), 2);
    do_restart(0);
    chk("restart err_illegal", 32'(err_a), 0);
    chk("restart words_written", 32'(ww_a), 0);
    send(3'd4, 2, 3, 0, 0, 16'h0007, 0, 32'h20430007);
    drain();
    chk("post-restart addr", 32'(mem_addr_a), 0);
    // restart with 3 queued words and a concurrent bundle
    do_restart(0);
    mem_ready = 0;
    for (int i = 1; i <= 3; i++) send(3'd5, 0, 0, 0, 0, 0, 26'(i), 32'h08000000 | i);
    do_restart(1);
    mem_ready = 1;
    repeat (6) @(negedge clk);
    chk("flush words_written", 32'(ww_a), 0);
    send(3'd3, 31, 31, 0, 0, 16'h1234, 0, 32'h13FF1234);
    drain();
    chk("flush next words_written", 32'(ww_a), 1);
    chk("flush next addr", 32'(mem_addr_a), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Builds 32-bit MIPS instruction words from decoded fields and writes them into instruction memory at consecutive word addresses. It is the producer side of the opcode/control path, emitting exactly the encodings the main decoder consumes (R-type, LW, SW, BEQ, ADDI, J). It sits between the test/boot program source and the instruction-memory write port. A small FIFO decouples the field interface from memory stalls.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_W, 6, instruction-memory word-address width
BASE_ADDR, 0, first word address written after reset or restart

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
in_kind  input  3  0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J; 6,7 illegal
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (RTYPE only)
in_funct  input  6  funct field (RTYPE only)
in_imm  input  16  immediate / offset (LW, SW, BEQ, ADDI)
in_target  input  26  jump target (J only)
restart  input  1  drop queued words, reload address to BASE_ADDR, clear err_illegal
mem_ready  input  1  memory accepts a write presented next cycle
mem_we  output  1  one-cycle write strobe
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  encoded instruction
err_illegal  output  1  sticky: illegal in_kind was presented
words_written  output  ADDR_W+1  count of mem_we pulses since reset/restart

Behaviour:
- The only clock is clk. reset is synchronous and active-high.
- Reset values: FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_illegal=0, words_written=0, in_ready=1.
- Accept: in_valid && in_ready. in_ready = !full || pop_this_cycle. Simultaneous push and pop on a full FIFO is allowed.
- Encoding, done combinationally at accept and stored in the FIFO:
  - RTYPE: {6'b000000, rs, rt, rd, 5'b0, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - ADDI: {6'b001000, rs, rt, imm}
  - J: {6'b000010, target}
  - Fields unused by a kind are ignored.
- Illegal kind (6, 7):
  - The bundle is consumed (in_ready stays as computed), not enqueued.
  - err_illegal is set and held until reset or restart.
- Drain:
  - In any cycle with FIFO non-empty and mem_ready=1, pop the head.
  - On the next edge: mem_we=1, mem_wdata=head, mem_addr=current address. The address counter then increments.
  - Otherwise mem_we=0; mem_addr and mem_wdata hold.
  - Minimum latency: bundle accepted in cycle N gives mem_we=1 in cycle N+2.
- Address wraps from 2^ADDR_W-1 to 0 with no flag. words_written saturates at all-ones.
- restart has priority over accept and drain in the same cycle:
  - FIFO flushed; a concurrent bundle is dropped.
  - mem_we=0 next cycle; address=BASE_ADDR; counters cleared.
- reset asserted mid-drain: no write strobe in the following cycle; all state returns to reset values.
- Write order equals accept order. No bundle is duplicated or lost except by restart or illegal kind.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, also usable by the main decoder;
  - in_kind enumeration constants;
  - funct constants ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- One sub-module, sync_fifo (parameterised WIDTH=32, DEPTH), with push, pop, full, empty, head.
- Encoder mux and address/count logic live in the top.

Test Plan:
- Single ADDI: kind=4, rs=0, rt=8, imm=0x0005, mem_ready=1 -> mem_we=1 in cycle N+2, mem_addr=0, mem_wdata=0x20080005.
- Stream of R add, LW, SW, BEQ, J:
  - R add: rs=8, rt=9, rd=10 -> 0x0109502A for SLT; use funct 100000 -> 0x01095020.
  - LW: rs=0, rt=8, imm=4 -> 0x8C080004.
  - SW: rs=0, rt=8, imm=8 -> 0xAC080008.
  - BEQ: rs=8, rt=9, imm=0xFFFF -> 0x1109FFFF.
  - J: target=0x0000010 -> 0x08000010.
  - Addresses 0..4 in order; words_written=5.
- Backpressure: hold mem_ready=0, push DEPTH+1 bundles.
  - in_ready drops after DEPTH accepts.
  - Release mem_ready: exactly DEPTH writes in order, then the pending bundle.
- Illegal kind=7 between two legal bundles -> err_illegal=1 and only 2 writes; restart -> err_illegal=0, next write at BASE_ADDR.
- Wrap: ADDR_W=2, 5 bundles -> mem_addr sequence 0,1,2,3,0.
- restart while FIFO holds 3 words and concurrent in_valid -> no further mem_we, next accepted bundle written at BASE_ADDR, words_written=1.
